// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion slice: screen/ball defaults,
// derived travel limits, FSM state type and the 4-bit speed type that the
// upstream speed stage also uses.
package ball_pkg;

    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int BALL_SIZE_DEF = 16;
    localparam int X_INIT_DEF    = 312;
    localparam int Y_INIT_DEF    = 232;

    // Largest legal top-left coordinate on each axis
    localparam int X_MAX = H_ACTIVE_DEF - BALL_SIZE_DEF;
    localparam int Y_MAX = V_ACTIVE_DEF - BALL_SIZE_DEF;

    typedef logic [3:0] speed_t;
    typedef logic [9:0] pos_t;

    typedef enum logic [0:0] {
        S_HOLD = 1'b0,
        S_MOVE = 1'b1
    } state_t;

    // Saturating increment used by the bounce counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Frame tick / speed inputs and position / bounce outputs of ball_motion.
// Optional feature macro: BALL_PAUSE_EN adds the iPause input.
interface ball_motion_if;
    import ball_pkg::*;

    logic       iFrame_tick;
    speed_t     iSpeed_X;
    speed_t     iSpeed_Y;
`ifdef BALL_PAUSE_EN
    logic       iPause;
`endif
    pos_t       oBall_X;
    pos_t       oBall_Y;
    logic       oDir_X;
    logic       oDir_Y;
    logic       oMoving;
    logic       oBounce;
    logic [7:0] oBounce_cnt;

`ifdef BALL_PAUSE_EN
    modport master (output iFrame_tick, iSpeed_X, iSpeed_Y, iPause,
                    input  oBall_X, oBall_Y, oDir_X, oDir_Y, oMoving, oBounce, oBounce_cnt);
    modport slave  (input  iFrame_tick, iSpeed_X, iSpeed_Y, iPause,
                    output oBall_X, oBall_Y, oDir_X, oDir_Y, oMoving, oBounce, oBounce_cnt);
`else
    modport master (output iFrame_tick, iSpeed_X, iSpeed_Y,
                    input  oBall_X, oBall_Y, oDir_X, oDir_Y, oMoving, oBounce, oBounce_cnt);
    modport slave  (input  iFrame_tick, iSpeed_X, iSpeed_Y,
                    output oBall_X, oBall_Y, oDir_X, oDir_Y, oMoving, oBounce, oBounce_cnt);
`endif

endinterface

// File: rtl/ball_axis_step.sv
// One-axis step with edge reflection. Purely combinational; the caller
// decides whether the result is committed.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int MAX = X_MAX
) (
    input  pos_t   pos,
    input  logic   dir,
    input  speed_t spd,
    output pos_t   nxt_pos,
    output logic   nxt_dir,
    output logic   hit
);

    localparam logic [10:0] MAX_W = 11'(MAX);

    logic [10:0] sum_s;
    logic [10:0] pos_w_s;
    logic [10:0] spd_w_s;

    // Widen to 11 bits so pos+spd can never wrap before the edge compare
    always_comb begin
        pos_w_s = {1'b0, pos};
        spd_w_s = {7'd0, spd};
        sum_s   = pos_w_s + spd_w_s;
    end

    // Advance in the current direction, clamping to the edge and reversing on contact
    always_comb begin
        nxt_pos = pos;
        nxt_dir = dir;
        hit     = 1'b0;
        if (spd == 4'd0) begin
            // A stationary axis never reflects, even when parked on an edge
            nxt_pos = pos;
            nxt_dir = dir;
            hit     = 1'b0;
        end else if (dir == 1'b1) begin
            if (sum_s >= MAX_W) begin
                nxt_pos = MAX_W[9:0];
                nxt_dir = 1'b0;
                hit     = 1'b1;
            end else begin
                nxt_pos = sum_s[9:0];
                nxt_dir = 1'b1;
                hit     = 1'b0;
            end
        end else begin
            if (pos_w_s <= spd_w_s) begin
                nxt_pos = 10'd0;
                nxt_dir = 1'b1;
                hit     = 1'b1;
            end else begin
                nxt_pos = pos - {6'd0, spd};
                nxt_dir = 1'b0;
                hit     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction state, HOLD/MOVE FSM and bounce counter.
// Updates only in the frame-tick cycle; results appear one clock later.
// Optional feature macro: BALL_PAUSE_EN (ticks are ignored while iPause=1).
module ball_motion
    import ball_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int BALL_SIZE = BALL_SIZE_DEF,
    parameter int X_INIT    = X_INIT_DEF,
    parameter int Y_INIT    = Y_INIT_DEF
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    ball_motion_if.slave  bus
);

    localparam int XMAX_P = H_ACTIVE - BALL_SIZE;
    localparam int YMAX_P = V_ACTIVE - BALL_SIZE;

    state_t     state_r;
    state_t     state_nxt_s;
    pos_t       pos_x_r;
    pos_t       pos_y_r;
    logic       dir_x_r;
    logic       dir_y_r;
    logic       moving_r;
    logic       bounce_r;
    logic [7:0] cnt_r;

    logic       tick_ok_s;
    logic       spd_any_s;
    logic       apply_s;
    pos_t       step_x_s;
    pos_t       step_y_s;
    logic       step_dx_s;
    logic       step_dy_s;
    logic       hit_x_s;
    logic       hit_y_s;
    pos_t       pos_x_nxt_s;
    pos_t       pos_y_nxt_s;
    logic       dir_x_nxt_s;
    logic       dir_y_nxt_s;
    logic       bounce_nxt_s;
    logic [7:0] cnt_nxt_s;

    ball_axis_step #(.MAX(XMAX_P)) u_step_x (
        .pos     (pos_x_r),
        .dir     (dir_x_r),
        .spd     (bus.iSpeed_X),
        .nxt_pos (step_x_s),
        .nxt_dir (step_dx_s),
        .hit     (hit_x_s)
    );

    ball_axis_step #(.MAX(YMAX_P)) u_step_y (
        .pos     (pos_y_r),
        .dir     (dir_y_r),
        .spd     (bus.iSpeed_Y),
        .nxt_pos (step_y_s),
        .nxt_dir (step_dy_s),
        .hit     (hit_y_s)
    );

    // Qualify the frame tick (pause gating) and detect any non-zero speed
    always_comb begin
`ifdef BALL_PAUSE_EN
        tick_ok_s = bus.iFrame_tick & ~bus.iPause;
`else
        tick_ok_s = bus.iFrame_tick;
`endif
        spd_any_s = (bus.iSpeed_X != 4'd0) || (bus.iSpeed_Y != 4'd0);
        apply_s   = tick_ok_s & spd_any_s;
    end

    // FSM state register
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_r <= S_HOLD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: start on a moving tick, stop on a zero-speed tick
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_HOLD: begin
                if (tick_ok_s && spd_any_s) begin
                    state_nxt_s = S_MOVE;
                end else begin
                    state_nxt_s = S_HOLD;
                end
            end
            S_MOVE: begin
                if (tick_ok_s && !spd_any_s) begin
                    state_nxt_s = S_HOLD;
                end else begin
                    state_nxt_s = S_MOVE;
                end
            end
            default: begin
                state_nxt_s = S_HOLD;
            end
        endcase
    end

    // FSM outputs: next position/direction, single bounce pulse for one or both axes
    always_comb begin
        pos_x_nxt_s  = pos_x_r;
        pos_y_nxt_s  = pos_y_r;
        dir_x_nxt_s  = dir_x_r;
        dir_y_nxt_s  = dir_y_r;
        bounce_nxt_s = 1'b0;
        cnt_nxt_s    = cnt_r;
        if (apply_s) begin
            pos_x_nxt_s  = step_x_s;
            pos_y_nxt_s  = step_y_s;
            dir_x_nxt_s  = step_dx_s;
            dir_y_nxt_s  = step_dy_s;
            bounce_nxt_s = hit_x_s | hit_y_s;
            if (hit_x_s || hit_y_s) begin
                cnt_nxt_s = sat_inc8(cnt_r);
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            bounce_nxt_s = 1'b0;
        end
    end

    // Registered outputs
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            pos_x_r  <= 10'(X_INIT);
            pos_y_r  <= 10'(Y_INIT);
            dir_x_r  <= 1'b1;
            dir_y_r  <= 1'b1;
            moving_r <= 1'b0;
            bounce_r <= 1'b0;
            cnt_r    <= 8'd0;
        end else begin
            pos_x_r  <= pos_x_nxt_s;
            pos_y_r  <= pos_y_nxt_s;
            dir_x_r  <= dir_x_nxt_s;
            dir_y_r  <= dir_y_nxt_s;
            moving_r <= (state_nxt_s == S_MOVE);
            bounce_r <= bounce_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign bus.oBall_X     = pos_x_r;
    assign bus.oBall_Y     = pos_y_r;
    assign bus.oDir_X      = dir_x_r;
    assign bus.oDir_Y      = dir_y_r;
    assign bus.oMoving     = moving_r;
    assign bus.oBounce     = bounce_r;
    assign bus.oBounce_cnt = cnt_r;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: the driver pushes the reference-model
// state for every tick/reset cycle, the monitor compares the DUT one clock later.
module tb_ball_motion;
    import ball_pkg::*;

    typedef struct {
        int x;
        int y;
        bit dx;
        bit dy;
        bit mv;
        bit b;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ball_motion_if bif();

    ball_motion dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bif.slave)
    );

    exp_t q[$];
    exp_t m;
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   ev_d  = 1'b0;
    bit   armed = 1'b0;

    // Reference: one axis moves spd pixels, clamps at 0 / mx and reverses there
    function automatic void axis(inout int pos, inout bit dir, input int spd, input int mx,
                                 output bit hit);
        hit = 1'b0;
        if (spd == 0) return;
        if (dir) begin
            if (pos + spd >= mx) begin pos = mx; dir = 1'b0; hit = 1'b1; end
            else pos = pos + spd;
        end else begin
            if (pos <= spd) begin pos = 0; dir = 1'b1; hit = 1'b1; end
            else pos = pos - spd;
        end
    endfunction

    function automatic void model_reset();
        m = '{x: X_INIT_DEF, y: Y_INIT_DEF, dx: 1'b1, dy: 1'b1, mv: 1'b0, b: 1'b0, cnt: 0};
    endfunction

    function automatic void model_tick(input int sx, input int sy, input bit pause);
        bit hx, hy;
        m.b = 1'b0;
        if (pause) return;
        if (sx == 0 && sy == 0) begin
            m.mv = 1'b0;
        end else begin
            axis(m.x, m.dx, sx, X_MAX, hx);
            axis(m.y, m.dy, sy, Y_MAX, hy);
            m.mv = 1'b1;
            if (hx || hy) begin
                m.b = 1'b1;
                if (m.cnt < 255) m.cnt++;
            end
        end
    endfunction

    task automatic drive(input bit tick, input int sx, input int sy, input bit rst, input bit pause);
        bif.iFrame_tick = tick;
        bif.iSpeed_X    = 4'(sx);
        bif.iSpeed_Y    = 4'(sy);
`ifdef BALL_PAUSE_EN
        bif.iPause      = pause;
`endif
        rst_n = !rst;
        if (rst) begin
            model_reset();
            q.push_back(m);
        end else if (tick) begin
            model_tick(sx, sy, pause);
            q.push_back(m);
        end
        @(posedge clk);
        #1;
        bif.iFrame_tick = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic ticks(input int n, input int sx, input int sy);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, sx, sy, 1'b0, 1'b0);
            drive(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b0);
        end
    endtask

    task automatic check(input string name, input exp_t e);
        n_cmp++;
        if (bif.oBall_X !== 10'(e.x) || bif.oBall_Y !== 10'(e.y) ||
            bif.oDir_X !== e.dx || bif.oDir_Y !== e.dy || bif.oMoving !== e.mv ||
            bif.oBounce !== e.b || bif.oBounce_cnt !== 8'(e.cnt)) begin
            n_bad++;
            $display("FAIL %s t=%0t got x=%0d y=%0d dx=%0b dy=%0b mv=%0b b=%0b cnt=%0d exp x=%0d y=%0d dx=%0b dy=%0b mv=%0b b=%0b cnt=%0d",
                     name, $time, bif.oBall_X, bif.oBall_Y, bif.oDir_X, bif.oDir_Y, bif.oMoving,
                     bif.oBounce, bif.oBounce_cnt, e.x, e.y, e.dx, e.dy, e.mv, e.b, e.cnt);
        end
    endtask

    // Remember whether the cycle just clocked carried an event the driver scored
    always @(posedge clk) ev_d <= bif.iFrame_tick || !rst_n;

    // Monitor: pop on event cycles, otherwise outputs must hold with no bounce
    always @(negedge clk) begin
        if (ev_d) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_empty t=%0t got empty queue, required an entry", $time);
            end else begin
                last  = q.pop_front();
                armed = 1'b1;
                check("update", last);
                last.b = 1'b0;
            end
        end else if (armed) begin
            check("hold", last);
        end
    end

    initial begin
        bif.iFrame_tick = 1'b0;
        bif.iSpeed_X    = 4'd0;
        bif.iSpeed_Y    = 4'd0;
`ifdef BALL_PAUSE_EN
        bif.iPause      = 1'b0;
`endif
        model_reset();

        // Reset, zero-speed tick, then 3/2 step and idle cycles
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        ticks(1, 0, 0);
        ticks(1, 3, 2);
        for (int i = 0; i < 4; i++) drive(1'b0, 9, 9, 1'b0, 1'b0);

        // Right edge: 312 -> 620 -> 624 with reversal
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        ticks(77, 4, 0);
        ticks(1, 5, 0);
        // Bottom edge, then walk both axes to X=2, Y=1 moving up-left
        ticks(29, 0, 8);
        ticks(30, 0, 15);
        ticks(1, 0, 13);
        ticks(41, 15, 0);
        ticks(1, 7, 0);
        // Both axes hit in the same tick
        ticks(1, 4, 4);
        // Zero speed while parked in the corner
        ticks(2, 0, 0);

        // Reset coincident with a moving tick
        ticks(5, 6, 9);
        drive(1'b1, 6, 9, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b0);

`ifdef BALL_PAUSE_EN
        ticks(3, 7, 5);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, $urandom_range(1, 15), $urandom_range(1, 15), 1'b0, 1'b1);
            drive(1'b0, 0, 0, 1'b0, 1'b0);
        end
`endif

        // Randomised traffic with occasional resets and pauses
        for (int i = 0; i < 1500; i++) begin
            int sx, sy;
            bit rs, ps;
            sx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            sy = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            rs = ($urandom_range(0, 99) == 0);
`ifdef BALL_PAUSE_EN
            ps = ($urandom_range(0, 3) == 0);
`else
            ps = 1'b0;
`endif
            drive(1'b1, sx, sy, rs, ps);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                drive(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 1'b0);
        end

        // Saturation of the bounce counter
        drive(1'b0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6000; i++) drive(1'b1, 15, 15, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drained got %0d entries left, required 0", q.size());
        end
        n_cmp++;
        if (bif.oBounce_cnt !== 8'd255) begin
            n_bad++;
            $display("FAIL bounce_saturate got %0d, required 255", bif.oBounce_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
